// File: rtl/coproc_pkg.sv
// Shared constants for the matrix coprocessor: opcodes, matrix geometry and sequencer states.
package coproc_pkg;

  localparam int LARGURA_ELEM   = 8;
  localparam int DIM_MATRIZ     = 5;
  localparam int LARGURA_MATRIZ = DIM_MATRIZ * DIM_MATRIZ * LARGURA_ELEM;
  localparam int LARGURA_OPCODE = 3;

  typedef logic [LARGURA_OPCODE-1:0] opcode_t;

  localparam opcode_t OP_SOMA   = 3'd0;
  localparam opcode_t OP_SUB    = 3'd1;
  localparam opcode_t OP_MULT   = 3'd2;
  localparam opcode_t OP_TRANSP = 3'd3;
  localparam opcode_t OP_OPOSTA = 3'd4;

  typedef enum logic [1:0] {
    OCIOSO,
    EXECUTA,
    LIBERA,
    RESPOSTA
  } estado_t;

  // Opcodes at or above the number of fitted units are answered with an error.
  function automatic logic opcode_valido(opcode_t op, int num_ops);
    return int'(op) < num_ops;
  endfunction

endpackage

// File: rtl/controle_coprocessador_if.sv
// Host-side instruction/response channel of the coprocessor sequencer (valid/ready both ways).
interface controle_coprocessador_if #(
  parameter int LARGURA_MATRIZ = coproc_pkg::LARGURA_MATRIZ
);

  logic                      instr_valid;
  logic                      instr_ready;
  logic [2:0]                instr_opcode;
  logic [LARGURA_MATRIZ-1:0] instr_matriz_a;
  logic [LARGURA_MATRIZ-1:0] instr_matriz_b;
  logic [LARGURA_MATRIZ-1:0] resultado;
  logic                      resultado_valid;
  logic                      resultado_ready;
  logic                      erro;

  modport master (
    output instr_valid, instr_opcode, instr_matriz_a, instr_matriz_b, resultado_ready,
    input  instr_ready, resultado, resultado_valid, erro
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_matriz_a, instr_matriz_b, resultado_ready,
    output instr_ready, resultado, resultado_valid, erro
  );

endinterface

// File: rtl/seletor_resultado.sv
// Combinational NUM_OPS:1 mux picking the result slice of the unit addressed by opcode.
module seletor_resultado
  import coproc_pkg::*;
#(
  parameter int NUM_OPS        = 8,
  parameter int LARGURA_MATRIZ = 200
) (
  input  logic [NUM_OPS*LARGURA_MATRIZ-1:0] resultado_op,
  input  opcode_t                           opcode,
  output logic [LARGURA_MATRIZ-1:0]         resultado
);

  always_comb begin
    resultado = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (opcode == LARGURA_OPCODE'(k)) begin
        resultado = resultado_op[k*LARGURA_MATRIZ +: LARGURA_MATRIZ];
      end
    end
  end

endmodule

// File: rtl/controle_coprocessador.sv
// Sequencer: accepts one instruction, runs the selected unit over a level start/done handshake, returns the result.
// Optional WATCHDOG_EN aborts a unit that stays busy for TIMEOUT_CICLOS cycles and reports erro.
module controle_coprocessador #(
  parameter int NUM_OPS        = 8,
  parameter int LARGURA_MATRIZ = coproc_pkg::LARGURA_MATRIZ,
  parameter int TIMEOUT_CICLOS = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  controle_coprocessador_if.slave           host,
  output logic [NUM_OPS-1:0]                start_op,
  input  logic [NUM_OPS-1:0]                done_op,
  output logic [LARGURA_MATRIZ-1:0]         op_matriz_a,
  output logic [LARGURA_MATRIZ-1:0]         op_matriz_b,
  input  logic [NUM_OPS*LARGURA_MATRIZ-1:0] resultado_op
);

  import coproc_pkg::*;

  if (NUM_OPS < 1 || NUM_OPS > (1 << LARGURA_OPCODE)) begin : g_num_ops_invalido
    $error("NUM_OPS must fit the opcode field");
  end
  if (TIMEOUT_CICLOS < 1) begin : g_timeout_invalido
    $error("TIMEOUT_CICLOS must be positive");
  end

  estado_t                   estado;
  opcode_t                   opcode_q;
  logic [LARGURA_MATRIZ-1:0] resultado_q;
  logic                      resultado_valid_q;
  logic                      erro_q;
  logic [LARGURA_MATRIZ-1:0] resultado_sel;
  logic [NUM_OPS-1:0]        sel_onehot;
  logic                      done_sel;
  logic                      start_ativo;

  seletor_resultado #(
    .NUM_OPS        (NUM_OPS),
    .LARGURA_MATRIZ (LARGURA_MATRIZ)
  ) u_seletor (
    .resultado_op (resultado_op),
    .opcode       (opcode_q),
    .resultado    (resultado_sel)
  );

  // Only the addressed unit's done is looked at; a stale done from any other unit is irrelevant.
  assign sel_onehot  = NUM_OPS'(1) << opcode_q;
  assign done_sel    = |(done_op & sel_onehot);
  assign start_ativo = |(start_op & sel_onehot);

  assign host.instr_ready     = (estado == OCIOSO);
  assign host.resultado       = resultado_q;
  assign host.resultado_valid = resultado_valid_q;
  assign host.erro            = erro_q;

`ifdef WATCHDOG_EN
  localparam int LARGURA_WD = ($clog2(TIMEOUT_CICLOS + 1) > 8) ? $clog2(TIMEOUT_CICLOS + 1) : 8;
  logic [LARGURA_WD-1:0] wd_cnt;
  logic                  wd_estouro;
  assign wd_estouro = (wd_cnt == LARGURA_WD'(TIMEOUT_CICLOS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado            <= OCIOSO;
      opcode_q          <= '0;
      start_op          <= '0;
      op_matriz_a       <= '0;
      op_matriz_b       <= '0;
      resultado_q       <= '0;
      resultado_valid_q <= 1'b0;
      erro_q            <= 1'b0;
`ifdef WATCHDOG_EN
      wd_cnt            <= '0;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          if (host.instr_valid) begin
            opcode_q    <= host.instr_opcode;
            op_matriz_a <= host.instr_matriz_a;
            op_matriz_b <= host.instr_matriz_b;
`ifdef WATCHDOG_EN
            wd_cnt      <= '0;
`endif
            if (opcode_valido(host.instr_opcode, NUM_OPS)) begin
              estado <= EXECUTA;
            end else begin
              resultado_q       <= '0;
              erro_q            <= 1'b1;
              resultado_valid_q <= 1'b1;
              estado            <= RESPOSTA;
            end
          end
        end

        // Start rises one cycle after acceptance, so done is only trusted once start is seen high.
        EXECUTA: begin
          start_op <= sel_onehot;
          if (start_ativo && done_sel) begin
            resultado_q <= resultado_sel;
            start_op    <= '0;
            estado      <= LIBERA;
          end
`ifdef WATCHDOG_EN
          else if (wd_estouro) begin
            start_op          <= '0;
            resultado_q       <= '0;
            erro_q            <= 1'b1;
            resultado_valid_q <= 1'b1;
            estado            <= RESPOSTA;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        // Wait for the unit to drop done so the next instruction sees a fresh rising done.
        LIBERA: begin
          start_op <= '0;
          if (!done_sel) begin
            resultado_valid_q <= 1'b1;
            estado            <= RESPOSTA;
          end
`ifdef WATCHDOG_EN
          else if (wd_estouro) begin
            resultado_q       <= '0;
            erro_q            <= 1'b1;
            resultado_valid_q <= 1'b1;
            estado            <= RESPOSTA;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        RESPOSTA: begin
          if (host.resultado_ready) begin
            resultado_valid_q <= 1'b0;
            erro_q            <= 1'b0;
            estado            <= OCIOSO;
          end
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
